// File: rtl/decoder_scan_pkg.sv
// Shared types and helpers for the registered one-hot decoder with scan mode.
// Widths here cover the largest legal select width; users truncate to their own OUT_W.
package decoder_scan_pkg;

    localparam int MAX_SEL_W = 6;
    localparam int MAX_OUT_W = 1 << MAX_SEL_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        logic [MAX_OUT_W-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/decoder_scan_if.sv
// Control inputs and decoded outputs of decoder_scan, bundled for the surrounding logic.
// master drives en/mode/sel/dwell; the decoder (slave) drives d/idx/wrap.
interface decoder_scan_if #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
);
    localparam int OUT_W = 1 << SEL_W;

    logic               en;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   d;
    logic [SEL_W-1:0]   idx;
    logic               wrap;

    modport master (
        output en, mode, sel, dwell,
        input  d, idx, wrap
    );

    modport slave (
        input  en, mode, sel, dwell,
        output d, idx, wrap
    );

endinterface

// File: rtl/decoder_scan.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with an autonomous scan mode that
// walks the active bit through every position, holding each for dwell+1 cycles.
module decoder_scan
    import decoder_scan_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    decoder_scan_if.slave   bus
);

    localparam int OUT_W = 1 << SEL_W;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   idx_q,   idx_d;
    logic [DWELL_W-1:0] cnt_q,   cnt_d;
    logic [OUT_W-1:0]   d_q,     d_d;
    logic               wrap_q,  wrap_d;
    logic [MAX_SEL_W-1:0] idx_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            d_q     <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;

        if (!bus.en) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else if (!bus.mode) begin
            state_d = DIRECT;
            idx_d   = bus.sel;
        end else if (state_q != SCAN) begin
            // Entering scan always restarts at position 0 with a freshly sampled dwell.
            state_d = SCAN;
            idx_d   = '0;
            cnt_d   = bus.dwell;
        end else if (cnt_q == '0) begin
            // idx wraps naturally modulo OUT_W because OUT_W is exactly 2**SEL_W.
            idx_d   = idx_q + 1'b1;
            cnt_d   = bus.dwell;
            wrap_d  = &idx_q;
        end else begin
            cnt_d   = cnt_q - 1'b1;
        end
    end

    // Output is re-decoded from the next index so it is one-hot by construction.
    always_comb begin
        idx_ext = MAX_SEL_W'(idx_d);
        d_d     = '0;
        if (state_d != IDLE) begin
            d_d = OUT_W'(onehot(idx_ext));
        end
    end

    assign bus.d    = d_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan: two instances (SEL_W=3 and SEL_W=4) share control
// stimulus; a position/hold-count reference model predicts each cycle's outputs.
module tb_decoder_scan;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decoder_scan_if #(.SEL_W(3), .DWELL_W(8)) bus3();
    decoder_scan_if #(.SEL_W(4), .DWELL_W(8)) bus4();

    decoder_scan #(.SEL_W(3), .DWELL_W(8)) u3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
    decoder_scan #(.SEL_W(4), .DWELL_W(8)) u4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    typedef struct {
        logic [63:0] d3;
        logic [63:0] d4;
        int          idx3;
        int          idx4;
        logic        w3;
        logic        w4;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    int total = 0;
    int bad   = 0;

    // Stimulus values applied to both instances
    bit en_v, mode_v;
    int sel3_v, sel4_v, dwell_v;

    // Reference model: whether scanning, current position, cycles spent at it, cycles owed
    int m_scan[2];
    int m_idx[2];
    int m_held[2];
    int m_tgt[2];
    int m_n[2] = '{8, 16};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_scan[i] = 0;
            m_idx[i]  = 0;
            m_held[i] = 0;
            m_tgt[i]  = 0;
        end
    endtask

    task automatic model_step(input int i, input int sel,
                              output logic [63:0] d, output int idx, output logic w);
        w = 1'b0;
        if (!en_v) begin
            m_scan[i] = 0;
            m_idx[i]  = 0;
        end else if (!mode_v) begin
            m_scan[i] = 0;
            m_idx[i]  = sel;
        end else if (m_scan[i] == 0) begin
            m_scan[i] = 1;
            m_idx[i]  = 0;
            m_held[i] = 1;
            m_tgt[i]  = dwell_v + 1;
        end else if (m_held[i] == m_tgt[i]) begin
            m_idx[i]  = (m_idx[i] + 1) % m_n[i];
            w         = (m_idx[i] == 0);
            m_held[i] = 1;
            m_tgt[i]  = dwell_v + 1;
        end else begin
            m_held[i]++;
        end
        idx = en_v ? m_idx[i] : 0;
        d   = en_v ? (64'd1 << m_idx[i]) : 64'd0;
    endtask

    // Drive current stimulus, record what the next edge must produce, advance to next negedge.
    task automatic cycle();
        exp_t x;
        bus3.en    = en_v;
        bus3.mode  = mode_v;
        bus3.sel   = 3'(sel3_v);
        bus3.dwell = 8'(dwell_v);
        bus4.en    = en_v;
        bus4.mode  = mode_v;
        bus4.sel   = 4'(sel4_v);
        bus4.dwell = 8'(dwell_v);
        model_step(0, sel3_v, x.d3, x.idx3, x.w3);
        model_step(1, sel4_v, x.d4, x.idx4, x.w4);
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_d3"},    64'(bus3.d),    64'd0);
        check({tag, "_idx3"},  64'(bus3.idx),  64'd0);
        check({tag, "_wrap3"}, 64'(bus3.wrap), 64'd0);
        check({tag, "_d4"},    64'(bus4.d),    64'd0);
        check({tag, "_idx4"},  64'(bus4.idx),  64'd0);
    endtask

    // Asynchronous reset pulse placed between edges; outputs must clear without a clock.
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("d3",    64'(bus3.d),    e.d3);
            check("idx3",  64'(bus3.idx),  64'(e.idx3));
            check("wrap3", 64'(bus3.wrap), 64'(e.w3));
            check("d4",    64'(bus4.d),    e.d4);
            check("idx4",  64'(bus4.idx),  64'(e.idx4));
            check("wrap4", 64'(bus4.wrap), 64'(e.w4));
        end
    end

    initial begin
        bit changed;
        int guard;

        rst_n   = 1'b0;
        en_v    = 1'b1;
        mode_v  = 1'b1;
        sel3_v  = 0;
        sel4_v  = 0;
        dwell_v = 0;
        bus3.en = 1'b1; bus3.mode = 1'b1; bus3.sel = '0; bus3.dwell = '0;
        bus4.en = 1'b1; bus4.mode = 1'b1; bus4.sel = '0; bus4.dwell = '0;
        model_reset();

        // Reset held with scan requested: outputs stay cleared across edges
        repeat (3) begin
            @(posedge clk);
            #1 check_zero("rst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Scan with dwell=0 through several sweeps of both widths
        repeat (40) cycle();

        // Direct truth table; sel=15 exercises the top bit of the 16-wide decoder
        mode_v = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sel3_v = i % 8;
            sel4_v = i;
            cycle();
        end

        // Scan dwell=2, switch dwell to 0 while position 3 is showing
        mode_v  = 1'b1;
        dwell_v = 2;
        changed = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!changed && m_idx[0] == 3) begin
                dwell_v = 0;
                changed = 1'b1;
            end
            cycle();
        end

        // Disable at idx=5, then re-enable
        guard = 0;
        while (m_idx[0] != 5 && guard < 64) begin
            cycle();
            guard++;
        end
        check("reach_idx5_en", 64'(m_idx[0]), 64'd5);
        en_v = 1'b0;
        repeat (2) cycle();
        en_v = 1'b1;
        repeat (6) cycle();

        // Asynchronous reset at idx=5
        guard = 0;
        while (m_idx[0] != 5 && guard < 64) begin
            cycle();
            guard++;
        end
        check("reach_idx5_rst", 64'(m_idx[0]), 64'd5);
        pulse_reset();
        repeat (6) cycle();

        // Restart scan with dwell=1: 32-cycle sweep on the 16-wide instance
        en_v = 1'b0;
        cycle();
        en_v    = 1'b1;
        dwell_v = 1;
        repeat (70) cycle();

        // Randomised traffic including occasional resets
        for (int i = 0; i < 400; i++) begin
            en_v    = ($urandom_range(0, 15) != 0);
            mode_v  = ($urandom_range(0, 4) != 0);
            sel3_v  = $urandom_range(0, 7);
            sel4_v  = $urandom_range(0, 15);
            dwell_v = $urandom_range(0, 3);
            if ($urandom_range(0, 99) == 0) pulse_reset();
            cycle();
        end

        @(posedge clk);
        #2;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder, successor to the team's fixed 3-to-8 decoder. Adds a clock, an enable, and an autonomous scan mode that walks the one-hot output through every position with a programmable dwell time. It sits between control logic and multiplexed outputs such as display digit or keypad row drivers. Direct mode reproduces the classic decoder truth table with one cycle of latency.

## Interface
Parameters:
- SEL_W, default 3: select width; output width OUT_W = 2**SEL_W (legal 1..6).
- DWELL_W, default 8: width of dwell-count input.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  block enable; 0 forces outputs inactive.
- mode  input  1  0 = direct decode, 1 = scan.
- sel  input  SEL_W  select in direct mode; MSB is sel[SEL_W-1] (3-bit case: a,b,c → sel[2],sel[1],sel[0]).
- dwell  input  DWELL_W  scan hold per position is dwell+1 cycles.
- d  output  OUT_W  registered one-hot output (all-zero when inactive).
- idx  output  SEL_W  index currently driven on d.
- wrap  output  1  one-cycle pulse on scan wrap from OUT_W-1 to 0.

## Operation
- FSM states: IDLE, DIRECT, SCAN. Reset state: IDLE.
- IDLE: d=0, idx=0, wrap=0, dwell counter cleared.
- Transitions are evaluated every cycle, with this priority:
  - en=0 → IDLE.
  - en=1, mode=0 → DIRECT.
  - en=1, mode=1 → SCAN.
- DIRECT:
  - Every cycle, d ← 1<<sel and idx ← sel.
  - Exactly one bit of d is high.
  - wrap=0.
- SCAN entry (from IDLE or DIRECT):
  - idx ← 0, d ← 1.
  - Dwell counter loaded with the sampled dwell.
- SCAN steady state:
  - Counter decrements each cycle.
  - When the counter is 0, idx advances (idx+1 modulo OUT_W), d rotates left by one, and the counter reloads from the current dwell.
- dwell is sampled only on entry and at each advance. A change mid-position takes effect on the next position.
- Wrap: when idx advances from OUT_W-1 to 0, wrap=1 for the cycle in which d=1 is first presented. Otherwise wrap=0.
- SCAN → DIRECT: d follows sel on the next cycle; scan position is discarded.
- DIRECT → SCAN: scan always restarts at idx=0.
- sel is ignored in SCAN and IDLE.
- Invariants:
  - d is one-hot in DIRECT/SCAN and zero in IDLE.
  - d == 1<<idx whenever d≠0.

## Timing
- All outputs are registered. Reset values: d=0, idx=0, wrap=0.
- Direct latency: sel/en/mode sampled at edge N, result on d after edge N.
- Scan period per position: dwell+1 cycles. dwell=0 advances every cycle. Full sweep: OUT_W·(dwell+1) cycles.
- wrap is high exactly one cycle per sweep, coincident with d=1 after the first sweep. It is not asserted on SCAN entry.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronous). After release, the block resumes from IDLE at the next edge per en/mode.
- en deasserted mid-scan: d=0 after the next edge. Re-enable restarts at idx=0.

## Structure
- Shared package: state enum (IDLE/DIRECT/SCAN), and function onehot(idx) returning 1<<idx at OUT_W width.
- Single module; no sub-module required.
- Dwell down-counter is inline, DWELL_W bits.
- Rotation is implemented as idx increment plus re-decode, not a separate shift register, so the one-hot invariant holds by construction.

## Test plan
- Reset: hold rst_n=0 with en=1, mode=1 → d=0, idx=0, wrap=0. Release → d=8'h01 after the first edge.
- Direct truth table: en=1, mode=0, sel stepped 0..7 with one cycle each → d=01,02,04,08,10,20,40,80, each one cycle after sel.
- Scan dwell=0:
  - d cycles 01→02→…→80→01 on consecutive edges.
  - wrap high only in cycles where d=01 after the first sweep; period 8 cycles.
- Scan dwell=2 with mid-run change: each position held 3 cycles. Setting dwell=0 during position 3 → position 3 still held 3 cycles, position 4 onward held 1 cycle.
- Interruptions mid-scan:
  - en=0 at idx=5 → d=0 next cycle; re-enable → d=01, idx=0.
  - rst_n pulsed low between edges at idx=5 → d=0 immediately.
- Parameter SEL_W=4, dwell=1: full sweep is 32 cycles, d covers 16'h0001..16'h8000, wrap once per 32 cycles. Direct sel=4'hF → d=16'h8000.
